mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single unified memory port shared by the pipeline's instruction fetch (IF) and data access (MEM) stages. Grants the port to one requester at a time, drives the memory handshake, returns read data with a one-cycle completion pulse, and generates the `iord` and stall signals consumed by the hazard unit. A watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the memory port arbiter, its two
// requesters (instruction fetch and data access) and the shared memory.
//   master : arbiter view (takes requests and memory responses, drives
//            completions, the memory strobe/address/data and hazard flags)
//   slave  : environment view (pipeline stages plus memory model)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    // data side
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    // memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    // hazard unit
    logic              iord;
    logic              if_stall;
    logic              mem_stall;
    logic              bus_err;

    modport master (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        output if_rdata, if_valid, dm_rdata, dm_done,
               mem_req, mem_we, mem_addr, mem_wdata,
               iord, if_stall, mem_stall, bus_err
    );

    modport slave (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        input  if_rdata, if_valid, dm_rdata, dm_done,
               mem_req, mem_we, mem_addr, mem_wdata,
               iord, if_stall, mem_stall, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single memory port shared by instruction fetch
// and data access. One access at a time, data side has priority, a
// watchdog aborts accesses the memory never acknowledges.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.master (requests, completions, memory
//            handshake, iord/stall/bus_err flags)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    // Watchdog count at which an unacknowledged access is abandoned.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    // An aborted access returns zero instead of whatever is on mem_rdata.
    function automatic logic [DATA_W-1:0] sel_rdata(input logic ack,
                                                    input logic [DATA_W-1:0] d);
        return ack ? d : '0;
    endfunction

    state_t            state_q, state_d;
    logic              grant_fetch, grant_data;

    logic [7:0]        wd_cnt_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              we_p0;

    logic              if_vld_p1, dm_vld_p1, err_p1;
    logic [DATA_W-1:0] if_rdata_p1, dm_rdata_p1;

    logic              dm_req, dm_req_live, if_req_live;
    logic              busy, wd_expire, finish, fetch_keep, data_end;

    // A requester still showing its completion pulse has not yet had a
    // chance to drop its request, so it must not be granted again.
    assign dm_req      = bus.dm_read | bus.dm_write;
    assign dm_req_live = dm_req & ~dm_vld_p1;
    assign if_req_live = bus.if_req & ~if_vld_p1;

    assign busy       = (state_q != IDLE);
    assign wd_expire  = busy & ~bus.mem_ack & (wd_cnt_p0 == WD_LAST);
    assign finish     = busy & (bus.mem_ack | wd_expire);
    // A fetch whose request vanished (pipeline flush) is completed silently.
    assign fetch_keep = (state_q == FETCH) & finish & bus.if_req;
    assign data_end   = (state_q == DATA) & finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req_live) begin
                    state_d    = DATA;
                    grant_data = 1'b1;
                end else if (if_req_live) begin
                    state_d     = FETCH;
                    grant_fetch = 1'b1;
                end
            end
            FETCH, DATA: begin
                if (finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant stage: capture the winning request and arm the watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_p0 <= '0;
            addr_p0   <= '0;
            wdata_p0  <= '0;
            we_p0     <= 1'b0;
        end else if (grant_data) begin
            wd_cnt_p0 <= '0;
            addr_p0   <= bus.dm_addr;
            wdata_p0  <= bus.dm_wdata;
            we_p0     <= bus.dm_write;
        end else if (grant_fetch) begin
            wd_cnt_p0 <= '0;
            addr_p0   <= bus.if_addr;
            we_p0     <= 1'b0;
        end else if (busy) begin
            wd_cnt_p0 <= wd_cnt_p0 + 8'd1;
        end
    end

    // Completion stage: one-cycle pulses and returned read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_vld_p1   <= 1'b0;
            dm_vld_p1   <= 1'b0;
            err_p1      <= 1'b0;
            if_rdata_p1 <= '0;
            dm_rdata_p1 <= '0;
        end else begin
            if_vld_p1 <= fetch_keep;
            dm_vld_p1 <= data_end;
            err_p1    <= wd_expire;
            if (fetch_keep) begin
                if_rdata_p1 <= sel_rdata(bus.mem_ack, bus.mem_rdata);
            end
            // Stores leave dm_rdata alone unless they are aborted.
            if (data_end && (wd_expire || !we_p0)) begin
                dm_rdata_p1 <= sel_rdata(bus.mem_ack, bus.mem_rdata);
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy & we_p0;
    assign bus.mem_addr  = addr_p0;
    assign bus.mem_wdata = wdata_p0;

    assign bus.if_valid  = if_vld_p1;
    assign bus.if_rdata  = if_rdata_p1;
    assign bus.dm_done   = dm_vld_p1;
    assign bus.dm_rdata  = dm_rdata_p1;
    assign bus.bus_err   = err_p1;

    // Flags held low while in reset so every output reads zero then.
    assign bus.iord      = rst_n & ((state_q == DATA) |
                                    ((state_q == IDLE) & dm_req_live));
    assign bus.if_stall  = rst_n & bus.if_req & ~if_vld_p1;
    assign bus.mem_stall = rst_n & dm_req & ~dm_vld_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    // Acknowledges the resp_wait-th cycle (0-based) of each mem_req burst;
    // resp_wait < 0 means never acknowledge.
    int          resp_wait = 0;
    int          resp_cnt  = 0;
    logic [31:0] resp_data = '0;
    bit          force_ack = 1'b0;
    logic        ack_r     = 1'b0;
    logic [31:0] rdata_r   = '0;
    assign bus.mem_ack   = ack_r;
    assign bus.mem_rdata = rdata_r;

    always @(negedge clk) begin
        if (bus.mem_req) begin
            ack_r = force_ack || (resp_wait >= 0 && resp_cnt == resp_wait);
            resp_cnt++;
        end else begin
            ack_r = force_ack;
            resp_cnt = 0;
        end
        rdata_r = resp_data;
    end

    // ---------------- behavioural model ----------------
    // owner: 0 none, 1 fetch, 2 data. used: cycles the access has lasted.
    int          owner = 0;
    int          used  = 0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic        e_ifv = 1'b0, e_dmd = 1'b0, e_err = 1'b0;
    logic [31:0] e_ifr = '0, e_dmr = '0;

    always @(posedge clk) begin
        logic nifv, ndmd, nerr, dmreq, r;
        logic [31:0] rd;
        if (!rst_n) begin
            owner = 0; used = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            e_ifv = 0; e_dmd = 0; e_err = 0; e_ifr = '0; e_dmr = '0;
        end else begin
            nifv = 0; ndmd = 0; nerr = 0;
            if (owner != 0) begin
                used++;
                if (bus.mem_ack || used == TO) begin
                    nerr = !bus.mem_ack;
                    rd   = bus.mem_ack ? bus.mem_rdata : 32'h0;
                    if (owner == 1) begin
                        if (bus.if_req) begin
                            nifv  = 1;
                            e_ifr = rd;
                        end
                    end else begin
                        ndmd = 1;
                        if (!m_we || nerr) e_dmr = rd;
                    end
                    owner = 0;
                end
            end else begin
                dmreq = bus.dm_read | bus.dm_write;
                if (dmreq && !e_dmd) begin
                    owner = 2; used = 0; m_we = bus.dm_write;
                    m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
                end else if (bus.if_req && !e_ifv) begin
                    owner = 1; used = 0; m_we = 0; m_addr = bus.if_addr;
                end
            end
            e_ifv = nifv; e_dmd = ndmd; e_err = nerr;
        end
        #1;
        r     = rst_n;
        dmreq = bus.dm_read | bus.dm_write;
        check("mem_req",   {31'b0, bus.mem_req},   {31'b0, owner != 0});
        check("mem_we",    {31'b0, bus.mem_we},    {31'b0, owner == 2 && m_we});
        check("mem_addr",  bus.mem_addr,  m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
        check("if_valid",  {31'b0, bus.if_valid},  {31'b0, e_ifv});
        check("if_rdata",  bus.if_rdata,  e_ifr);
        check("dm_done",   {31'b0, bus.dm_done},   {31'b0, e_dmd});
        check("dm_rdata",  bus.dm_rdata,  e_dmr);
        check("bus_err",   {31'b0, bus.bus_err},   {31'b0, e_err});
        check("iord",      {31'b0, bus.iord},
              {31'b0, r && (owner == 2 || (owner == 0 && dmreq && !e_dmd))});
        check("if_stall",  {31'b0, bus.if_stall},  {31'b0, r && bus.if_req && !e_ifv});
        check("mem_stall", {31'b0, bus.mem_stall}, {31'b0, r && dmreq && !e_dmd});
    end

    // Waits for a completion pulse, counting mem_req cycles on the way.
    task automatic wait_pulse(input bit data_side, input int budget, output int reqs);
        reqs = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (data_side ? bus.dm_done : bus.if_valid) return;
            if (bus.mem_req) reqs++;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_pulse(data=%0d): no completion within %0d cycles", data_side, budget);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int reqs;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.dm_read = 1'b0; bus.dm_write = 1'b0;
        bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
        force_ack = 1'b1; resp_data = 32'hFFFF_FFFF;

        // Reset held with fetch request and ack active
        repeat (2) @(negedge clk);
        check("rst mem_req",  {31'b0, bus.mem_req},  32'h0);
        check("rst if_valid", {31'b0, bus.if_valid}, 32'h0);
        check("rst if_stall", {31'b0, bus.if_stall}, 32'h0);
        check("rst iord",     {31'b0, bus.iord},     32'h0);
        check("rst if_rdata", bus.if_rdata, 32'h0);
        check("rst mem_addr", bus.mem_addr, 32'h0);

        // Release straight into a zero-wait fetch of 0x40
        rst_n = 1'b1; force_ack = 1'b0; resp_wait = 0;
        resp_data = 32'h8C22_0004; bus.if_addr = 32'h40;
        @(negedge clk);
        check("zw mem_req",  {31'b0, bus.mem_req}, 32'h1);
        check("zw mem_addr", bus.mem_addr, 32'h40);
        @(negedge clk);
        check("zw if_valid", {31'b0, bus.if_valid}, 32'h1);
        check("zw if_rdata", bus.if_rdata, 32'h8C22_0004);
        check("zw idle",     {31'b0, bus.mem_req},  32'h0);
        @(negedge clk);
        check("zw no regrant", {31'b0, bus.mem_req}, 32'h0);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Contention: data wins, fetch follows
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.dm_read = 1'b1; bus.dm_addr = 32'h100;
        resp_wait = 1; resp_data = 32'h1234;
        #1 check("ct iord idle", {31'b0, bus.iord}, 32'h1);
        wait_pulse(1'b1, 20, reqs);
        check("ct dm_rdata", bus.dm_rdata, 32'h1234);
        check("ct if_stall", {31'b0, bus.if_stall}, 32'h1);
        check("ct reqs",     reqs, 32'd2);
        bus.dm_read = 1'b0; resp_data = 32'hCAFE_F00D;
        wait_pulse(1'b0, 20, reqs);
        check("ct if_rdata", bus.if_rdata, 32'hCAFE_F00D);
        check("ct f_addr",   bus.mem_addr, 32'h44);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Watchdog abort with no ack
        bus.dm_read = 1'b1; bus.dm_addr = 32'h200; resp_wait = -1;
        wait_pulse(1'b1, 20, reqs);
        check("to reqs",     reqs, 32'd4);
        check("to bus_err",  {31'b0, bus.bus_err}, 32'h1);
        check("to dm_rdata", bus.dm_rdata, 32'h0);
        bus.dm_read = 1'b0;
        @(negedge clk);
        check("to err drop", {31'b0, bus.bus_err}, 32'h0);

        // Ack in the abort cycle wins
        bus.dm_read = 1'b1; bus.dm_addr = 32'h204;
        resp_wait = 3; resp_data = 32'h55AA;
        wait_pulse(1'b1, 20, reqs);
        check("ta reqs",     reqs, 32'd4);
        check("ta bus_err",  {31'b0, bus.bus_err}, 32'h0);
        check("ta dm_rdata", bus.dm_rdata, 32'h55AA);
        bus.dm_read = 1'b0;
        @(negedge clk);

        // Flush: fetch dropped one cycle in, store queued behind it
        bus.if_req = 1'b1; bus.if_addr = 32'h80; resp_data = 32'hDEAD_0001;
        @(negedge clk);
        check("fl mem_addr", bus.mem_addr, 32'h80);
        bus.if_req = 1'b0;
        bus.dm_write = 1'b1; bus.dm_addr = 32'h300; bus.dm_wdata = 32'hA5A5_A5A5;
        repeat (4) @(negedge clk);
        check("fl if_valid",  {31'b0, bus.if_valid}, 32'h0);
        check("fl if_rdata",  bus.if_rdata, 32'hCAFE_F00D);
        check("fl mem_req",   {31'b0, bus.mem_req}, 32'h0);
        check("fl mem_stall", {31'b0, bus.mem_stall}, 32'h1);
        resp_wait = -1;
        @(negedge clk);
        check("st mem_req",   {31'b0, bus.mem_req}, 32'h1);
        check("st mem_we",    {31'b0, bus.mem_we},  32'h1);
        check("st mem_addr",  bus.mem_addr,  32'h300);
        check("st mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);

        // Reset two cycles into the store
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar mem_req", {31'b0, bus.mem_req}, 32'h0);
        check("ar mem_we",  {31'b0, bus.mem_we},  32'h0);
        @(negedge clk);
        rst_n = 1'b1; resp_wait = 0;
        @(negedge clk);
        check("rg mem_req",  {31'b0, bus.mem_req}, 32'h1);
        check("rg mem_we",   {31'b0, bus.mem_we},  32'h1);
        check("rg mem_addr", bus.mem_addr, 32'h300);
        @(negedge clk);
        check("rg dm_done",  {31'b0, bus.dm_done}, 32'h1);
        check("rg dm_rdata", bus.dm_rdata, 32'h0);
        bus.dm_write = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
